fir_param: RTL and testbench

- Parametrised FIR filter with AXI-Lite configuration, AXI-Stream input and output.
- Tap count is programmable at run time up to MAX_TAPS; coefficients and sample history are held in internal registers.
- Output is arithmetically right-shifted and saturated.
- Generalised successor of the fixed 11-tap FIR block. Sits between the stream source/sink and the AXI-Lite control master.

---
 rtl/fir_param.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fir_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param.sv
// fir_param: run-time configurable FIR filter.
//
// A single multiply-accumulate unit walks the taps, one per clock. Tap count,
// output shift, run length and coefficients are programmed over AXI-Lite;
// samples arrive on an AXI-Stream slave and results leave on an AXI-Stream
// master.
//
// Ports
//   axis_clk, axis_rst_n        clock, asynchronous active-low reset
//   aw*/w*                      AXI-Lite write address/data channel
//   ar*/r*                      AXI-Lite read address/data channel
//   ss_tvalid/tready/tdata/tlast  input sample stream (tlast is not used)
//   sm_tvalid/tready/tdata/tlast  output sample stream, tlast marks final output
//
// Register map (byte addresses)
//   0x00  ap_ctrl      bit0 ap_start (write 1), bit1 ap_done (clears on read),
//                      bit2 ap_idle (read-only)
//   0x10  data_length  outputs per run
//   0x14  tap_num      0 or values above MAX_TAPS are stored as MAX_TAPS
//   0x18  out_shift    arithmetic right shift applied to the accumulator
//   0x20+4k coef[k]
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for ap_start, ss_tready low
//   WAIT_IN | ss_tready high, waiting for the next sample
//   MAC     | one coefficient*history product accumulated per cycle
//   OUT     | result presented on sm_*, held until sm_tready

module fir_param #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_TAPS = 32,
  parameter int ACC_W    = 2*DATA_W+8
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  input  logic              ss_tvalid,
  output logic              ss_tready,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              sm_tvalid,
  input  logic              sm_tready,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast
);

  localparam int TAP_W     = $clog2(MAX_TAPS + 1);
  localparam int KW        = $clog2(MAX_TAPS);
  localparam int COEF_BASE = 32'h20;
  localparam int COEF_END  = COEF_BASE + 4*MAX_TAPS;

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_LEN   = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_TAPS  = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_SHIFT = ADDR_W'(32'h18);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_IN = 2'd1;
  localparam logic [1:0] S_MAC     = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]               state;
  logic                     ap_done;
  logic                     ap_idle;
  logic [DATA_W-1:0]        data_length;
  logic [DATA_W-1:0]        sample_cnt;
  logic [DATA_W-1:0]        cnt_inc;
  logic [TAP_W-1:0]         tap_num;
  logic [TAP_W-1:0]         mac_cnt;
  logic [4:0]               out_shift;
  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] coef    [MAX_TAPS];
  logic signed [DATA_W-1:0] history [MAX_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        y_sat;
  logic                     wr_ack;
  logic                     wr_fire;
  logic                     rd_fire;
  logic                     start_req;
  logic                     done_clr;
  logic [DATA_W-1:0]        rd_val;
  logic                     unused_tlast;

  assign unused_tlast = ss_tlast;

  function automatic logic is_coef(input logic [ADDR_W-1:0] a);
    return (int'(a) >= COEF_BASE) && (int'(a) < COEF_END) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [KW-1:0] coef_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - ADDR_W'(COEF_BASE)) >> 2;
    return KW'(off);
  endfunction

  function automatic logic [TAP_W-1:0] clamp_taps(input logic [DATA_W-1:0] v);
    if ((v == '0) || (v > DATA_W'(MAX_TAPS))) return TAP_W'(MAX_TAPS);
    return TAP_W'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // AXI-Lite handshakes
  // ---------------------------------------------------------------------------
  assign awready   = wr_ack;
  assign wready    = wr_ack;
  assign wr_fire   = awvalid & wvalid & wr_ack;
  assign rd_fire   = arvalid & arready;
  assign start_req = wr_fire && (awaddr == A_CTRL) && wdata[0] && ap_idle;
  assign done_clr  = rd_fire && (araddr == A_CTRL);

  always_comb begin
    rd_val = '0;
    if (araddr == A_CTRL)        rd_val = DATA_W'({ap_idle, ap_done, 1'b0});
    else if (araddr == A_LEN)    rd_val = data_length;
    else if (araddr == A_TAPS)   rd_val = DATA_W'(tap_num);
    else if (araddr == A_SHIFT)  rd_val = DATA_W'(out_shift);
    else if (is_coef(araddr))    rd_val = coef[coef_idx(araddr)];
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ack  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      // ready registers pulse for exactly one cycle per request
      wr_ack  <= awvalid & wvalid & ~wr_ack;
      arready <= arvalid & ~arready & ~rvalid;
      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers; frozen while a run is in progress
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      data_length <= '0;
      tap_num     <= TAP_W'(MAX_TAPS);
      out_shift   <= '0;
      for (int i = 0; i < MAX_TAPS; i++) coef[i] <= '0;
    end else if (wr_fire && ap_idle) begin
      if (awaddr == A_LEN)        data_length <= wdata;
      else if (awaddr == A_TAPS)  tap_num     <= clamp_taps(wdata);
      else if (awaddr == A_SHIFT) out_shift   <= wdata[4:0];
      else if (is_coef(awaddr))   coef[coef_idx(awaddr)] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Operands are sign-extended to the product width, so the low 2*DATA_W bits
  // of the unsigned multiply equal the signed product.
  assign prod     = {{DATA_W{coef[k][DATA_W-1]}}, coef[k]} *
                    {{DATA_W{history[k][DATA_W-1]}}, history[k]};
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign shifted  = acc >>> out_shift;

  always_comb begin
    if (shifted > SAT_MAX)      y_sat = Y_MAX;
    else if (shifted < SAT_MIN) y_sat = Y_MIN;
    else                        y_sat = shifted[DATA_W-1:0];
  end

  assign cnt_inc   = sample_cnt + DATA_W'(1);
  assign ss_tready = (state == S_WAIT_IN);
  assign sm_tvalid = (state == S_OUT);
  // acc and out_shift cannot change while in OUT, so sm_tdata stays stable
  assign sm_tdata  = (state == S_OUT) ? y_sat : '0;
  assign sm_tlast  = (state == S_OUT) && (cnt_inc == data_length);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state      <= S_IDLE;
      ap_done    <= 1'b0;
      ap_idle    <= 1'b1;
      sample_cnt <= '0;
      mac_cnt    <= '0;
      k          <= '0;
      acc        <= '0;
      for (int i = 0; i < MAX_TAPS; i++) history[i] <= '0;
    end else begin
      if (done_clr) ap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req) begin
            sample_cnt <= '0;
            for (int i = 0; i < MAX_TAPS; i++) history[i] <= '0;
            if (data_length == '0) begin
              ap_done <= 1'b1;
            end else begin
              ap_done <= 1'b0;
              ap_idle <= 1'b0;
              state   <= S_WAIT_IN;
            end
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            history[0] <= ss_tdata;
            for (int i = 1; i < MAX_TAPS; i++) history[i] <= history[i-1];
            acc     <= '0;
            k       <= '0;
            mac_cnt <= tap_num - TAP_W'(1);
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          k   <= k + KW'(1);
          if (mac_cnt == '0) state <= S_OUT;
          else               mac_cnt <= mac_cnt - TAP_W'(1);
        end
        S_OUT: begin
          if (sm_tready) begin
            sample_cnt <= cnt_inc;
            if (cnt_inc == data_length) begin
              ap_done <= 1'b1;
              ap_idle <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_WAIT_IN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_param.sv
module tb_fir_param;

  logic        axis_clk   = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [11:0] awaddr  = '0;
  logic        wvalid  = 1'b0, wready;
  logic [31:0] wdata   = '0;
  logic        arvalid = 1'b0, arready;
  logic [11:0] araddr  = '0;
  logic        rvalid;
  logic        rready  = 1'b0;
  logic [31:0] rdata;
  logic        ss_tvalid = 1'b0, ss_tready;
  logic [31:0] ss_tdata  = '0;
  logic        ss_tlast  = 1'b0;
  logic        sm_tvalid;
  logic        sm_tready = 1'b0;
  logic [31:0] sm_tdata;
  logic        sm_tlast;

  fir_param #(.ADDR_W(12), .DATA_W(32), .MAX_TAPS(32)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [31:0]       coef0;
    logic [7:0]        taps;
    logic [4:0]        shift;
    logic [7:0]        len;
    logic [7:0]        stall;   // output index held back for 20 cycles, 8'hFF for none
    logic [11:0][31:0] din;
    logic [11:0][31:0] dout;
  } vec_t;

  vec_t        tbl [8];
  int          cf  [11];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no handshake, want handshake within bound", name);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge axis_clk); n++; end while (!awready && n < 20);
    if (!awready) timeout("axi_write");
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge axis_clk); n++; end while (!arready && n < 20);
    if (!arready) timeout("axi_read_ar");
    @(negedge axis_clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge axis_clk); n++; end
    if (!rvalid) timeout("axi_read_r");
    d = rdata;
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    ss_tdata = d; ss_tvalid = 1'b1;
    while (!ss_tready && n < 200) begin @(negedge axis_clk); n++; end
    if (!ss_tready) timeout("ss_handshake");
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
  endtask

  task automatic recv(input logic [31:0] exp, input bit exp_last, input bit stall, input logic [31:0] next_in);
    int n = 0;
    while (!sm_tvalid && n < 200) begin @(negedge axis_clk); n++; end
    if (!sm_tvalid) begin
      timeout("sm_handshake");
    end else begin
      check("sm_tdata", sm_tdata, exp);
      check("sm_tlast", 32'(sm_tlast), 32'(exp_last));
      if (stall) begin
        // offer the next sample during the stall; it must not be taken
        ss_tdata = next_in; ss_tvalid = 1'b1;
        repeat (20) begin
          @(negedge axis_clk);
          check("stall_data", sm_tdata, exp);
          check("stall_ss_tready", 32'(ss_tready), 32'd0);
        end
        ss_tvalid = 1'b0;
      end
      sm_tready = 1'b1;
      @(negedge axis_clk);
      sm_tready = 1'b0;
    end
  endtask

  task automatic do_run(input vec_t v, input bit poke);
    logic [31:0] rd;
    int len;
    len = int'(v.len);
    axi_write(12'h020, v.coef0);
    axi_write(12'h014, 32'(v.taps));
    axi_write(12'h018, 32'(v.shift));
    axi_write(12'h010, 32'(v.len));
    axi_write(12'h000, 32'd1);
    for (int i = 0; i < len; i++) begin
      send(v.din[i]);
      if (poke && i == 0) begin
        axi_write(12'h024, 32'd5);
        axi_write(12'h000, 32'd1);
        axi_read(12'h000, rd);
        check("busy_ctrl", rd, 32'h0);
      end
      recv(v.dout[i], (i == len-1), (i == int'(v.stall)), (i+1 < len) ? v.din[i+1] : 32'd0);
    end
    axi_read(12'h000, rd);
    check("done_ctrl", rd, 32'h6);
    axi_read(12'h000, rd);
    check("done_cleared", rd, 32'h4);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, 32'({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}), 32'd0);
    check({name, "_rdata"}, rdata, 32'd0);
    check({name, "_sm_tdata"}, sm_tdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    cf = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '0;
      tbl[i].stall = 8'hFF;
    end
    // impulse response, with a stall on output 5
    tbl[0].taps = 8'd11; tbl[0].len = 8'd12; tbl[0].stall = 8'd5;
    tbl[0].din[0] = 32'd1;
    for (int i = 0; i < 11; i++) tbl[0].dout[i] = cf[i];
    // 3 taps, step input
    tbl[1].taps = 8'd3; tbl[1].len = 8'd4;
    for (int i = 0; i < 4; i++) tbl[1].din[i] = 32'd1;
    tbl[1].dout[1] = -10; tbl[1].dout[2] = -19; tbl[1].dout[3] = -19;
    // 11 taps, shift 1
    tbl[2].taps = 8'd11; tbl[2].shift = 5'd1; tbl[2].len = 8'd4;
    tbl[2].din[0] = 4; tbl[2].din[1] = -2; tbl[2].din[2] = 0; tbl[2].din[3] = 100;
    tbl[2].dout[1] = -20; tbl[2].dout[2] = -8; tbl[2].dout[3] = 55;
    // 2 taps, shift 2, negative results round toward minus infinity
    tbl[3].taps = 8'd2; tbl[3].shift = 5'd2; tbl[3].len = 8'd3;
    tbl[3].din[0] = 1; tbl[3].din[1] = 2; tbl[3].din[2] = -1;
    tbl[3].dout[1] = -3; tbl[3].dout[2] = -5;
    // saturation / large shift, single tap with coef[0] = 0x7FFFFFFF
    for (int i = 4; i < 8; i++) begin
      tbl[i].coef0 = 32'h7FFF_FFFF; tbl[i].taps = 8'd1; tbl[i].len = 8'd1;
    end
    tbl[4].din[0] = 32'h7FFF_FFFF; tbl[4].dout[0] = 32'h7FFF_FFFF;
    tbl[5].din[0] = 32'h7FFF_FFFF; tbl[5].shift = 5'd31; tbl[5].dout[0] = 32'h7FFF_FFFE;
    tbl[6].din[0] = 32'h8000_0000; tbl[6].dout[0] = 32'h8000_0000;
    tbl[7].din[0] = 32'h8000_0000; tbl[7].shift = 5'd31; tbl[7].dout[0] = 32'h8000_0001;

    // reset state
    #1 axis_rst_n = 1'b0;
    #2 check_zero("reset");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    axi_read(12'h000, r); check("rst_ctrl", r, 32'h4);
    axi_read(12'h014, r); check("rst_taps", r, 32'd32);
    axi_read(12'h018, r); check("rst_shift", r, 32'd0);
    axi_read(12'h010, r); check("rst_len", r, 32'd0);
    axi_read(12'h024, r); check("rst_coef1", r, 32'd0);

    // register map
    for (int i = 0; i < 11; i++) axi_write(12'(32'h20 + 4*i), cf[i]);
    axi_read(12'h030, r); check("coef4", r, 32'd56);
    axi_read(12'h024, r); check("coef1", r, 32'hFFFF_FFF6);
    axi_write(12'h09C, 32'h1234); axi_read(12'h09C, r); check("coef31", r, 32'h1234);
    axi_write(12'h014, 32'd0);   axi_read(12'h014, r); check("taps_zero", r, 32'd32);
    axi_write(12'h014, 32'd33);  axi_read(12'h014, r); check("taps_33", r, 32'd32);
    axi_write(12'h014, 32'd2);   axi_read(12'h014, r); check("taps_2", r, 32'd2);
    axi_write(12'h00C, 32'hDEAD); axi_read(12'h00C, r); check("unmapped_0c", r, 32'd0);
    axi_read(12'h0A0, r); check("unmapped_a0", r, 32'd0);

    // simultaneous read and write
    fork
      axi_write(12'h018, 32'd3);
      axi_read(12'h014, r);
    join
    check("simul_read", r, 32'd2);
    axi_read(12'h018, r); check("simul_write", r, 32'd3);

    // rdata held while rready is low
    axi_write(12'h014, 32'd11);
    araddr = 12'h014; arvalid = 1'b1;
    begin
      int n = 0;
      do begin @(negedge axis_clk); n++; end while (!arready && n < 20);
      if (!arready) timeout("hold_ar");
    end
    @(negedge axis_clk);
    arvalid = 1'b0;
    repeat (5) begin
      check("hold_rvalid", 32'(rvalid), 32'd1);
      check("hold_rdata", rdata, 32'd11);
      @(negedge axis_clk);
    end
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;
    check("hold_release", 32'(rvalid), 32'd0);

    // table-driven runs
    for (int i = 0; i < 8; i++) do_run(tbl[i], 1'b0);

    // back-to-back runs; the middle one pokes config and ap_start while busy
    for (int i = 0; i < 3; i++) do_run(tbl[1], (i == 1));
    axi_read(12'h024, r); check("busy_coef1", r, 32'hFFFF_FFF6);

    // data_length = 0: immediate done, no stream traffic
    axi_write(12'h010, 32'd0);
    axi_write(12'h000, 32'd1);
    check("len0_ss_tready", 32'(ss_tready), 32'd0);
    axi_read(12'h000, r); check("len0_ctrl", r, 32'h6);
    axi_read(12'h000, r); check("len0_cleared", r, 32'h4);

    // reset while an output is waiting
    axi_write(12'h020, 32'd0);
    axi_write(12'h014, 32'd11);
    axi_write(12'h018, 32'd0);
    axi_write(12'h010, 32'd4);
    axi_read(12'h014, r); check("pre_rst_taps", r, 32'd11);
    axi_write(12'h000, 32'd1);
    send(32'd5);
    recv(32'd0, 1'b0, 1'b0, 32'd0);
    send(32'd3);
    begin
      int n = 0;
      while (!sm_tvalid && n < 200) begin @(negedge axis_clk); n++; end
    end
    check("pre_rst_valid", 32'(sm_tvalid), 32'd1);
    check("pre_rst_data", sm_tdata, -50);
    #2 axis_rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    axi_read(12'h000, r); check("post_rst_ctrl", r, 32'h4);
    axi_read(12'h024, r); check("post_rst_coef1", r, 32'd0);
    axi_read(12'h014, r); check("post_rst_taps", r, 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
